// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALUop classes, R-type funct codes and multiplier states.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ORI   = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// 32-iteration shift-add multiplier producing the low 32 bits of op_a * op_b.
// Operands are captured on start in IDLE; done is a single-cycle DONE state.
module seq_multiplier
    import pipeline_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // counter wraps to zero on the 32nd iteration
                if (cnt_q == 5'd31) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= 5'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: MEM/WB forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MULT_EN to build the stalling sequential multiplier (funct 0x18).
module ex_stage
    import pipeline_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        RegDst_ex,
    input  logic        MemRead_ex,
    input  logic        MemtoReg_ex,
    input  logic        MemWrite_ex,
    input  logic        ALUSrc_ex,
    input  logic        RegWrite_ex,
    input  logic [1:0]  ALUop_ex,
    input  logic [31:0] Instruction_ex,
    input  logic [31:0] ReadData1_ex,
    input  logic [31:0] ReadData2_ex,
    input  logic [31:0] Extended_ex,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rd_ex,
    input  logic        RegWrite_wb,
    input  logic [4:0]  WriteReg_wb,
    input  logic [31:0] WriteData_wb,
    output logic        MemRead_mem,
    output logic        MemtoReg_mem,
    output logic        MemWrite_mem,
    output logic        RegWrite_mem,
    output logic [31:0] ALUResult_mem,
    output logic [31:0] WriteData_mem,
    output logic [4:0]  WriteReg_mem,
    output logic        EXStall
);

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
    logic [4:0]  wr_reg;
    logic        stall;
    logic        unused_instr;

    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] write_data_q, write_data_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic        mem_read_q, mem_read_d, mem_to_reg_q, mem_to_reg_d;
    logic        mem_write_q, mem_write_d, reg_write_q, reg_write_d;

    assign funct        = Instruction_ex[5:0];
    assign shamt        = Instruction_ex[10:6];
    assign unused_instr = ^Instruction_ex[31:11];
    assign wr_reg       = RegDst_ex ? rd_ex : rt_ex;

    // MEM result is younger than WB, so it takes priority; r0 is never forwarded
    always_comb begin
        fwd_a = ReadData1_ex;
        fwd_b = ReadData2_ex;
        if (reg_write_q && write_reg_q == rs_ex && write_reg_q != 5'd0)
            fwd_a = alu_result_q;
        else if (RegWrite_wb && WriteReg_wb == rs_ex && WriteReg_wb != 5'd0)
            fwd_a = WriteData_wb;
        if (reg_write_q && write_reg_q == rt_ex && write_reg_q != 5'd0)
            fwd_b = alu_result_q;
        else if (RegWrite_wb && WriteReg_wb == rt_ex && WriteReg_wb != 5'd0)
            fwd_b = WriteData_wb;
    end

    assign alu_b = ALUSrc_ex ? Extended_ex : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        case (aluop_e'(ALUop_ex))
            ALUOP_ADD: alu_res = fwd_a + alu_b;
            ALUOP_SUB: alu_res = fwd_a - alu_b;
            ALUOP_ORI: alu_res = fwd_a | {16'd0, Extended_ex[15:0]};
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_res = fwd_a + alu_b;
                    FUNCT_SUB: alu_res = fwd_a - alu_b;
                    FUNCT_AND: alu_res = fwd_a & alu_b;
                    FUNCT_OR:  alu_res = fwd_a | alu_b;
                    FUNCT_NOR: alu_res = ~(fwd_a | alu_b);
                    FUNCT_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
                    FUNCT_SLL: alu_res = fwd_b << shamt;
                    FUNCT_SRL: alu_res = fwd_b >> shamt;
                    default:   alu_res = 32'd0;
                endcase
            end
            default: alu_res = 32'd0;
        endcase
    end

`ifdef EX_MULT_EN
    logic        is_mul, mul_start, mul_busy, mul_done;
    logic [31:0] mul_product;
    logic [4:0]  mul_reg_q, mul_reg_d;
    logic        mul_mr_q, mul_mr_d, mul_mtr_q, mul_mtr_d;
    logic        mul_mw_q, mul_mw_d, mul_rw_q, mul_rw_d;

    assign is_mul    = (ALUop_ex == ALUOP_FUNCT) && (funct == FUNCT_MUL);
    assign mul_start = is_mul && !mul_busy && !mul_done;
    assign stall     = mul_start || mul_busy;

    seq_multiplier u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .op_a    (fwd_a),
        .op_b    (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Destination and controls of the mul are held until DONE writes EX/MEM
    always_comb begin
        mul_reg_d = mul_reg_q;
        mul_mr_d  = mul_mr_q;
        mul_mtr_d = mul_mtr_q;
        mul_mw_d  = mul_mw_q;
        mul_rw_d  = mul_rw_q;
        if (mul_start) begin
            mul_reg_d = wr_reg;
            mul_mr_d  = MemRead_ex;
            mul_mtr_d = MemtoReg_ex;
            mul_mw_d  = MemWrite_ex;
            mul_rw_d  = RegWrite_ex;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_reg_q <= 5'd0;
            mul_mr_q  <= 1'b0;
            mul_mtr_q <= 1'b0;
            mul_mw_q  <= 1'b0;
            mul_rw_q  <= 1'b0;
        end else begin
            mul_reg_q <= mul_reg_d;
            mul_mr_q  <= mul_mr_d;
            mul_mtr_q <= mul_mtr_d;
            mul_mw_q  <= mul_mw_d;
            mul_rw_q  <= mul_rw_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        alu_result_d = alu_res;
        write_data_d = fwd_b;
        write_reg_d  = wr_reg;
        mem_read_d   = MemRead_ex;
        mem_to_reg_d = MemtoReg_ex;
        mem_write_d  = MemWrite_ex;
        reg_write_d  = RegWrite_ex;
`ifdef EX_MULT_EN
        // DONE ignores the bubble sitting in ID/EX and retires the product
        if (mul_done) begin
            alu_result_d = mul_product;
            write_data_d = 32'd0;
            write_reg_d  = mul_reg_q;
            mem_read_d   = mul_mr_q;
            mem_to_reg_d = mul_mtr_q;
            mem_write_d  = mul_mw_q;
            reg_write_d  = mul_rw_q;
        end
`endif
        if (stall) begin
            alu_result_d = 32'd0;
            write_data_d = 32'd0;
            write_reg_d  = 5'd0;
            mem_read_d   = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_result_q <= 32'd0;
            write_data_q <= 32'd0;
            write_reg_q  <= 5'd0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign ALUResult_mem = alu_result_q;
    assign WriteData_mem = write_data_q;
    assign WriteReg_mem  = write_reg_q;
    assign MemRead_mem   = mem_read_q;
    assign MemtoReg_mem  = mem_to_reg_q;
    assign MemWrite_mem  = mem_write_q;
    assign RegWrite_mem  = reg_write_q;
    assign EXStall       = stall;

endmodule
